// File: rtl/udi_iq_sample_fifo.sv
// I/Q sample FIFO feeding the UDI register file: ADC pairs in, one {I,Q} word per pop out.
// Optional 16-bit saturating overflow counter enabled by defining UDI_IQFIFO_OVF_CNT_EN.
module udi_iq_sample_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  gclk,
   input  logic                  greset,
   input  logic                  adc_valid,
   input  logic [15:0]           adc_i,
   input  logic [15:0]           adc_q,
   input  logic                  udi_ctl_pop,
   input  logic                  udi_ctl_stat,
   input  logic                  udi_ctl_flush,
   output logic [31:0]           out_rd,
   output logic                  fifo_nempty,
   output logic [DEPTH_LOG2:0]   fifo_level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LEVEL = DEPTH[DEPTH_LOG2:0];

   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   level;
   logic                  ovf_flag;
   logic [15:0]           ovf_cnt;

   logic full;
   logic empty;
   logic pop_eff;
   logic push_eff;
   logic drop;

   // A pop frees the slot a same-cycle push lands in, so a full FIFO still accepts.
   always_comb begin
      full     = (level == FULL_LEVEL);
      empty    = (level == '0);
      pop_eff  = udi_ctl_pop && !empty;
      push_eff = adc_valid && (!full || pop_eff);
      drop     = adc_valid && full && !pop_eff;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge gclk or posedge greset) begin
      if (greset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         ovf_flag <= 1'b0;
      end else if (udi_ctl_flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         ovf_flag <= 1'b0;
      end else begin
         if (push_eff) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop_eff)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         case ({push_eff, pop_eff})
            2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
            2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
            default: level <= level;
         endcase
         if (drop) ovf_flag <= 1'b1;
      end
   end

   // NOTE: storage is deliberately left out of reset; the level counter alone decides what is valid.
   always_ff @(posedge gclk) begin
      if (push_eff && !udi_ctl_flush) mem[wr_ptr] <= {adc_i, adc_q};
   end

`ifdef UDI_IQFIFO_OVF_CNT_EN
   always_ff @(posedge gclk or posedge greset) begin
      if (greset) begin
         ovf_cnt <= '0;
      end else if (udi_ctl_flush) begin
         ovf_cnt <= '0;
      end else if (drop && ovf_cnt != 16'hFFFF) begin
         ovf_cnt <= ovf_cnt + 16'd1;
      end
   end
`else
   assign ovf_cnt = '0;
`endif

   // NOTE: every combinational output gets a default first so no latch can be inferred.
   always_comb begin
      logic [31:0] status;
      status        = '0;
      status[7:0]   = 8'(level);
      status[8]     = ovf_flag;
      status[31:16] = ovf_cnt;
      out_rd        = '0;
      if (udi_ctl_stat)  out_rd = status;
      else if (!empty)   out_rd = mem[rd_ptr];
   end

   assign fifo_nempty = !empty;
   assign fifo_level  = level;

endmodule

// File: tb/tb_udi_iq_sample_fifo.sv
// Self-checking bench for udi_iq_sample_fifo: directed scenarios plus random traffic
// checked against a queue-based model of the sample buffer.
module tb_udi_iq_sample_fifo;

   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 1 << DEPTH_LOG2;

   logic                gclk = 1'b0;
   logic                greset;
   logic                adc_valid;
   logic [15:0]         adc_i;
   logic [15:0]         adc_q;
   logic                udi_ctl_pop;
   logic                udi_ctl_stat;
   logic                udi_ctl_flush;
   logic [31:0]         out_rd;
   logic                fifo_nempty;
   logic [DEPTH_LOG2:0] fifo_level;

   udi_iq_sample_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
      .gclk          (gclk),
      .greset        (greset),
      .adc_valid     (adc_valid),
      .adc_i         (adc_i),
      .adc_q         (adc_q),
      .udi_ctl_pop   (udi_ctl_pop),
      .udi_ctl_stat  (udi_ctl_stat),
      .udi_ctl_flush (udi_ctl_flush),
      .out_rd        (out_rd),
      .fifo_nempty   (fifo_nempty),
      .fifo_level    (fifo_level)
   );

   always #5 gclk = ~gclk;

   int checks = 0;
   int errors = 0;

   // Reference model: the buffer is simply a queue of packed words.
   logic [31:0] mq[$];
   logic        m_ovf;
   int          m_cnt;

   function automatic logic [31:0] exp_head();
      if (mq.size() == 0) return 32'h0;
      return mq[0];
   endfunction

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s       = '0;
      s[7:0]  = 8'(mq.size());
      s[8]    = m_ovf;
`ifdef UDI_IQFIFO_OVF_CNT_EN
      s[31:16] = 16'(m_cnt);
`endif
      return s;
   endfunction

   function automatic int exp_drop_cnt(input int drops);
`ifdef UDI_IQFIFO_OVF_CNT_EN
      return drops;
`else
      return 0 * drops;
`endif
   endfunction

   task automatic model_clear();
      mq.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
   endtask

   task automatic model_step(input logic v, input logic [31:0] d, input logic pop, input logic flush);
      if (flush) begin
         model_clear();
      end else begin
         if (pop && mq.size() != 0) void'(mq.pop_front());
         if (v) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else begin
               m_ovf = 1'b1;
               if (m_cnt < 65535) m_cnt++;
            end
         end
      end
   endtask

   // One clock: inputs applied now, edge taken, model advanced, outputs settle at edge+1.
   task automatic cycle(input logic v, input logic [15:0] i, input logic [15:0] q,
                        input logic pop, input logic flush);
      adc_valid     = v;
      adc_i         = i;
      adc_q         = q;
      udi_ctl_pop   = pop;
      udi_ctl_flush = flush;
      @(posedge gclk);
      model_step(v, {i, q}, pop, flush);
      #1;
      adc_valid     = 1'b0;
      udi_ctl_pop   = 1'b0;
      udi_ctl_flush = 1'b0;
   endtask

   task automatic read_status(output logic [31:0] s);
      udi_ctl_stat = 1'b1;
      #1;
      s = out_rd;
      udi_ctl_stat = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] s;
      greset = 1'b1;
      repeat (2) @(posedge gclk);
      #1;
      checks++;
      if (fifo_level !== '0 || fifo_nempty !== 1'b0 || out_rd !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: level=%0d nempty=%b out_rd=%h, want 0/0/00000000",
                  fifo_level, fifo_nempty, out_rd);
      end
      read_status(s);
      checks++;
      if (s !== 32'h0) begin
         errors++;
         $display("FAIL reset_status: got %h want 00000000", s);
      end
      greset = 1'b0;
      model_clear();
   endtask

   task automatic test_basic();
      logic [31:0] want [3];
      want = '{32'h0001FFFF, 32'h7FFF8000, 32'h12345678};
      cycle(1'b1, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
      cycle(1'b1, 16'h7FFF, 16'h8000, 1'b0, 1'b0);
      cycle(1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0);
      checks++;
      if (fifo_level !== 5'd3 || fifo_nempty !== 1'b1) begin
         errors++;
         $display("FAIL basic_level: level=%0d nempty=%b want 3/1", fifo_level, fifo_nempty);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_rd !== want[k]) begin
            errors++;
            $display("FAIL basic_pop%0d: got %h want %h", k, out_rd, want[k]);
         end
         cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      end
      checks++;
      if (fifo_level !== '0 || fifo_nempty !== 1'b0 || out_rd !== 32'h0) begin
         errors++;
         $display("FAIL basic_empty: level=%0d nempty=%b out_rd=%h want 0/0/0",
                  fifo_level, fifo_nempty, out_rd);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] s;
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      for (int k = 0; k < DEPTH + 2; k++)
         cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      checks++;
      if (fifo_level !== 5'd16) begin
         errors++;
         $display("FAIL ovf_level: got %0d want 16", fifo_level);
      end
      read_status(s);
      checks++;
      if (s[8] !== 1'b1 || s[31:16] !== 16'(exp_drop_cnt(2)) || s[7:0] !== 8'd16 || s[15:9] !== '0) begin
         errors++;
         $display("FAIL ovf_status: got %h want flag=1 cnt=%0d level=16", s, exp_drop_cnt(2));
      end
      for (int k = 0; k < DEPTH; k++) begin
         checks++;
         if (out_rd !== exp_head()) begin
            errors++;
            $display("FAIL ovf_order%0d: got %h want %h", k, out_rd, exp_head());
         end
         cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      end
      checks++;
      if (fifo_nempty !== 1'b0 || out_rd !== 32'h0) begin
         errors++;
         $display("FAIL ovf_drained: nempty=%b out_rd=%h want 0/0", fifo_nempty, out_rd);
      end
   endtask

   task automatic test_full_pushpop();
      logic [31:0] s;
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      for (int k = 0; k < DEPTH; k++)
         cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (out_rd !== exp_head()) begin
            errors++;
            $display("FAIL fullpp_head%0d: got %h want %h", k, out_rd, exp_head());
         end
         cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
         read_status(s);
         checks++;
         if (fifo_level !== 5'd16 || s[8] !== 1'b0) begin
            errors++;
            $display("FAIL fullpp_level%0d: level=%0d flag=%b want 16/0", k, fifo_level, s[8]);
         end
      end
      for (int k = 0; k < DEPTH; k++) begin
         checks++;
         if (out_rd !== exp_head()) begin
            errors++;
            $display("FAIL fullpp_drain%0d: got %h want %h", k, out_rd, exp_head());
         end
         cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_empty_pushpop();
      logic [15:0] i;
      logic [15:0] q;
      i = 16'($urandom);
      q = 16'($urandom);
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      cycle(1'b1, i, q, 1'b1, 1'b0);
      checks++;
      if (fifo_level !== 5'd1 || out_rd !== {i, q}) begin
         errors++;
         $display("FAIL emptypp: level=%0d out_rd=%h want 1/%h", fifo_level, out_rd, {i, q});
      end
      cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      checks++;
      if (fifo_level !== '0 || fifo_nempty !== 1'b0 || out_rd !== 32'h0) begin
         errors++;
         $display("FAIL pop_on_empty: level=%0d nempty=%b out_rd=%h want 0/0/0",
                  fifo_level, fifo_nempty, out_rd);
      end
   endtask

   task automatic test_flush();
      logic [31:0] s;
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      for (int k = 0; k < DEPTH + 1; k++)
         cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      read_status(s);
      checks++;
      if (s[8] !== 1'b1 || fifo_level !== 5'd16) begin
         errors++;
         $display("FAIL flush_pre: flag=%b level=%0d want 1/16", s[8], fifo_level);
      end
      cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1);
      read_status(s);
      checks++;
      if (fifo_level !== '0 || s !== 32'h0 || out_rd !== 32'h0) begin
         errors++;
         $display("FAIL flush_post: level=%0d status=%h out_rd=%h want 0/00000000/0",
                  fifo_level, s, out_rd);
      end
   endtask

   task automatic test_async_reset();
      logic [15:0] i;
      logic [15:0] q;
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      for (int k = 0; k < 7; k++)
         cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      checks++;
      if (fifo_level !== 5'd7) begin
         errors++;
         $display("FAIL areset_pre: level=%0d want 7", fifo_level);
      end
      #2;
      greset = 1'b1;
      #1;
      checks++;
      if (fifo_level !== '0 || fifo_nempty !== 1'b0 || out_rd !== 32'h0) begin
         errors++;
         $display("FAIL areset_now: level=%0d nempty=%b out_rd=%h want 0/0/0",
                  fifo_level, fifo_nempty, out_rd);
      end
      #1;
      greset = 1'b0;
      model_clear();
      i = 16'($urandom);
      q = 16'($urandom);
      cycle(1'b1, i, q, 1'b0, 1'b0);
      checks++;
      if (fifo_level !== 5'd1 || out_rd !== {i, q}) begin
         errors++;
         $display("FAIL areset_push: level=%0d out_rd=%h want 1/%h", fifo_level, out_rd, {i, q});
      end
   endtask

   task automatic test_random();
      logic [31:0] s;
      int          push_pct;
      int          pop_pct;
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      for (int n = 0; n < 600; n++) begin
         push_pct = (n % 200 < 100) ? 80 : 30;
         pop_pct  = (n % 200 < 100) ? 30 : 80;
         cycle($urandom_range(0, 99) < push_pct, 16'($urandom), 16'($urandom),
               $urandom_range(0, 99) < pop_pct, $urandom_range(0, 99) < 2);
         read_status(s);
         checks++;
         if (fifo_level !== (DEPTH_LOG2 + 1)'(mq.size()) || fifo_nempty !== (mq.size() != 0)
             || out_rd !== exp_head() || s !== exp_status()) begin
            errors++;
            $display("FAIL random%0d: level=%0d out_rd=%h status=%h want %0d/%h/%h",
                     n, fifo_level, out_rd, s, mq.size(), exp_head(), exp_status());
         end
      end
   endtask

   initial begin
      adc_valid     = 1'b0;
      adc_i         = '0;
      adc_q         = '0;
      udi_ctl_pop   = 1'b0;
      udi_ctl_stat  = 1'b0;
      udi_ctl_flush = 1'b0;
      model_clear();
      test_reset();
      test_basic();
      test_overflow();
      test_full_pushpop();
      test_empty_pushpop();
      test_flush();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
